touch_coord_filter: RTL and testbench
=====================================

Name: touch_coord_filter

Overview:
- Sits between adc_spi_controller and touch_irq_detector in the touch path of the LTM panel design.
- Consumes raw 12-bit digitizer X/Y samples and their new-coordinate strobe.
- Rejects outlier samples and averages a block of 2^N_LOG2 consistent samples.
- Scales the average to panel pixel coordinates (800x480), tracks pen-down/pen-up, and emits a clean coordinate strobe plus a release pulse.

Parameters:
- N_LOG2, 2: log2 of the number of samples averaged per output (4).
- THRESH, 64: maximum allowed |sample - reference| per axis, in raw ADC counts.
- RELEASE_CYC, 1000: consecutive iCLK cycles with iTOUCH_IRQ low that declare pen-up.
- H_RES, 800: panel width in pixels.
- V_RES, 480: panel height in pixels.

Ports:
- iCLK  in  1  system clock, 50 MHz CLOCK_50 domain.
- iRST_n  in  1  reset; asynchronous assert, active-low.
- iTOUCH_IRQ  in  1  pen-down indication from the ADC controller (high = touched).
- iX_COORD  in  12  raw X sample.
- iY_COORD  in  12  raw Y sample.
- iNEW_COORD  in  1  one-cycle strobe; iX/iY are valid in that cycle.
- oX_PIX  out  10  filtered X pixel, range 0..H_RES-1.
- oY_PIX  out  9  filtered Y pixel, range 0..V_RES-1.
- oNEW_COORD  out  1  one-cycle strobe; oX_PIX/oY_PIX were updated this cycle.
- oTOUCH_VALID  out  1  high from the first output strobe until release.
- oRELEASE  out  1  one-cycle pulse at the pen-up decision.
- oREJECT_CNT  out  8  saturating count of outlier restarts since reset.

Behaviour:
- Reset (async, iRST_n=0):
  - All outputs go to 0.
  - Accumulators, sample count, reference registers and release counter are cleared.
  - State returns to IDLE.
  - Reset mid-accumulation discards the partial block; no strobe is produced.
- A sample is accepted only when iNEW_COORD=1 and iTOUCH_IRQ=1 in the same cycle. iNEW_COORD with iTOUCH_IRQ=0 is ignored.
- States:
  - IDLE: on an accepted sample, ref<=sample, acc<=sample, cnt<=1, then go to ACCUM.
  - ACCUM: on an accepted sample, if |x-refx|>THRESH or |y-refy|>THRESH, restart the block with this sample (ref=acc=sample, cnt=1) and increment oREJECT_CNT (saturates at 255). Otherwise acc+=sample and cnt+=1. When cnt reaches 2^N_LOG2, go to AVG.
  - AVG: avg<=acc>>N_LOG2 (truncating), then go to SCALE.
  - SCALE: pix<=(avg*H_RES)>>12 and (avg*V_RES)>>12, using unsigned 12xW multiplies with truncation, so max raw 4095 maps to H_RES-1/V_RES-1. Then go to OUT.
  - OUT: drive oX_PIX/oY_PIX, pulse oNEW_COORD for one cycle, set oTOUCH_VALID=1, clear acc/cnt, then go to IDLE. The next block takes a fresh reference.
- Widths: accumulators are 12+N_LOG2 bits and cannot overflow. The threshold compare uses 13-bit signed differences.
- Latency: oNEW_COORD is high in the 3rd cycle after the edge that accepted the final sample (AVG, SCALE, OUT). Samples arriving during AVG/SCALE/OUT are dropped and are not counted as rejects.
- oX_PIX/oY_PIX hold their last value between strobes and through release.
- Release counter:
  - Increments each cycle iTOUCH_IRQ=0, saturating at RELEASE_CYC.
  - Clears on any cycle iTOUCH_IRQ=1.
  - On reaching RELEASE_CYC: oRELEASE pulses once, oTOUCH_VALID<=0, acc/cnt cleared, state<=IDLE. This happens even if no output was ever produced.
  - No further oRELEASE until iTOUCH_IRQ has gone high again.
- Simultaneous events: release takes priority over a pending OUT strobe in the same cycle. When both occur, the strobe is suppressed and the release wins.

Decomposition:
- Shared package touch_pkg holds:
  - state enum (IDLE, ACCUM, AVG, SCALE, OUT);
  - ADC_W=12, PIX_X_W=10, PIX_Y_W=9;
  - default H_RES/V_RES.
- One sub-module, coord_scale: a registered multiply-and-shift of one axis, parameterised by resolution. Instantiated twice, for X and Y.

Test Plan:
- Scenario 1: IRQ=1; samples x=2048,2050,2046,2048 and y=1024 x4 -> 3 cycles after the 4th: oNEW_COORD=1, oX_PIX=400, oY_PIX=120, oTOUCH_VALID=1.
- Scenario 2: samples x=2048 then 2200 (delta 152>64), then 2200 x3, y=2048 -> oREJECT_CNT=1; output oX_PIX=429, oY_PIX=240.
- Scenario 3: four samples x=y=4095 -> oX_PIX=799, oY_PIX=479; four samples of 0 -> 0,0.
- Scenario 4: after a valid output, IRQ low 999 cycles then high -> no oRELEASE; IRQ low 1000 cycles -> single oRELEASE, oTOUCH_VALID=0, pixels unchanged.
- Scenario 5: reset after 2 accepted samples, then 4 new samples of x=y=1000 -> output matches those 4 only: X=195, Y=117.
- Scenario 6: iNEW_COORD pulses with IRQ=0, and during AVG/SCALE -> ignored; no count change, no reject increment.

Source files
------------

// File: rtl/touch_pkg.sv
// Shared types and constants for the touch coordinate filter path.
package touch_pkg;

  localparam int ADC_W     = 12;
  localparam int PIX_X_W   = 10;
  localparam int PIX_Y_W   = 9;
  localparam int H_RES_DEF = 800;
  localparam int V_RES_DEF = 480;

  typedef enum logic [2:0] {IDLE, ACCUM, AVG, SCALE, OUT} state_e;

  typedef struct packed {
    logic [ADC_W-1:0] x;
    logic [ADC_W-1:0] y;
  } sample_t;

  // True when |a - b| exceeds thresh, using a 13-bit signed difference.
  function automatic logic outside_window(input logic [ADC_W-1:0] a,
                                          input logic [ADC_W-1:0] b,
                                          input int unsigned      thresh);
    logic signed [ADC_W:0] diff;
    logic        [ADC_W:0] mag;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    mag  = diff[ADC_W] ? -diff : diff;
    return 32'(mag) > thresh;
  endfunction

endpackage

// File: rtl/coord_scale.sv
// Registered raw-to-pixel scaling of one axis: pix = (avg * RES) >> ADC_W.
module coord_scale
  import touch_pkg::*;
#(
  parameter int RES   = H_RES_DEF,
  parameter int OUT_W = PIX_X_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [ADC_W-1:0] avg,
  output logic [OUT_W-1:0] pix
);

  localparam int                PROD_W = ADC_W + OUT_W;
  localparam logic [PROD_W-1:0] RES_K  = PROD_W'(RES);

  logic [OUT_W-1:0] pix_d, pix_q;

  always_comb begin
    pix_d = pix_q;
    if (en) pix_d = OUT_W'((PROD_W'(avg) * RES_K) >> ADC_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_q <= '0;
    else        pix_q <= pix_d;
  end

  assign pix = pix_q;

endmodule

// File: rtl/touch_coord_filter.sv
// Outlier-rejecting block averager for raw touch samples, scaled to panel
// pixels, with pen-up detection after a run of IRQ-low cycles.
module touch_coord_filter
  import touch_pkg::*;
#(
  parameter int N_LOG2      = 2,
  parameter int THRESH      = 64,
  parameter int RELEASE_CYC = 1000,
  parameter int H_RES       = H_RES_DEF,
  parameter int V_RES       = V_RES_DEF
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic               iTOUCH_IRQ,
  input  logic [ADC_W-1:0]   iX_COORD,
  input  logic [ADC_W-1:0]   iY_COORD,
  input  logic               iNEW_COORD,
  output logic [PIX_X_W-1:0] oX_PIX,
  output logic [PIX_Y_W-1:0] oY_PIX,
  output logic               oNEW_COORD,
  output logic               oTOUCH_VALID,
  output logic               oRELEASE,
  output logic [7:0]         oREJECT_CNT
);

  localparam int               ACC_W   = ADC_W + N_LOG2;
  localparam int               CNT_W   = N_LOG2 + 1;
  localparam int               REL_W   = $clog2(RELEASE_CYC + 1);
  localparam logic [CNT_W-1:0] SAMPLES = CNT_W'(1 << N_LOG2);
  localparam logic [REL_W-1:0] REL_MAX = REL_W'(RELEASE_CYC);

  state_e           state_d, state_q;
  logic [ACC_W-1:0] acc_x_d, acc_x_q, acc_y_d, acc_y_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  sample_t          ref_d, ref_q, avg_d, avg_q;
  logic [7:0]       rej_d, rej_q;
  logic [REL_W-1:0] rel_cnt_d, rel_cnt_q;
  logic             new_coord_d, new_coord_q;
  logic             valid_d, valid_q;
  logic             rel_pulse_d, rel_pulse_q;
  logic             scale_en;

  sample_t smp;
  logic    accept, outlier, rel_fire;

  assign smp      = {iX_COORD, iY_COORD};
  assign accept   = iNEW_COORD & iTOUCH_IRQ;
  assign outlier  = outside_window(smp.x, ref_q.x, THRESH) |
                    outside_window(smp.y, ref_q.y, THRESH);
  assign rel_fire = !iTOUCH_IRQ && (rel_cnt_q == REL_MAX - 1'b1);

  // NOTE: every signal gets its hold value first so no path through this
  // block leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    cnt_d       = cnt_q;
    ref_d       = ref_q;
    avg_d       = avg_q;
    rej_d       = rej_q;
    rel_cnt_d   = rel_cnt_q;
    valid_d     = valid_q;
    new_coord_d = 1'b0;
    rel_pulse_d = 1'b0;
    scale_en    = 1'b0;

    if (iTOUCH_IRQ)                rel_cnt_d = '0;
    else if (rel_cnt_q != REL_MAX) rel_cnt_d = rel_cnt_q + 1'b1;

    case (state_q)
      IDLE: if (accept) begin
        ref_d   = smp;
        acc_x_d = ACC_W'(smp.x);
        acc_y_d = ACC_W'(smp.y);
        cnt_d   = CNT_W'(1);
        state_d = ACCUM;
      end
      ACCUM: if (accept) begin
        if (outlier) begin
          ref_d   = smp;
          acc_x_d = ACC_W'(smp.x);
          acc_y_d = ACC_W'(smp.y);
          cnt_d   = CNT_W'(1);
          if (rej_q != 8'hFF) rej_d = rej_q + 8'd1;
        end else begin
          acc_x_d = acc_x_q + ACC_W'(smp.x);
          acc_y_d = acc_y_q + ACC_W'(smp.y);
          cnt_d   = cnt_q + 1'b1;
          if (cnt_d == SAMPLES) state_d = AVG;
        end
      end
      AVG: begin
        avg_d.x = ADC_W'(acc_x_q >> N_LOG2);
        avg_d.y = ADC_W'(acc_y_q >> N_LOG2);
        state_d = SCALE;
      end
      SCALE: begin
        scale_en    = 1'b1;
        new_coord_d = 1'b1;
        valid_d     = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        acc_x_d = '0;
        acc_y_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Pen-up wins over a strobe that would otherwise land in the same cycle;
    // the scaler is held too so the pixels never change without a strobe.
    if (rel_fire) begin
      rel_pulse_d = 1'b1;
      valid_d     = 1'b0;
      new_coord_d = 1'b0;
      scale_en    = 1'b0;
      acc_x_d     = '0;
      acc_y_d     = '0;
      cnt_d       = '0;
      state_d     = IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= IDLE;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      cnt_q       <= '0;
      ref_q       <= '0;
      avg_q       <= '0;
      rej_q       <= '0;
      rel_cnt_q   <= '0;
      new_coord_q <= 1'b0;
      valid_q     <= 1'b0;
      rel_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      cnt_q       <= cnt_d;
      ref_q       <= ref_d;
      avg_q       <= avg_d;
      rej_q       <= rej_d;
      rel_cnt_q   <= rel_cnt_d;
      new_coord_q <= new_coord_d;
      valid_q     <= valid_d;
      rel_pulse_q <= rel_pulse_d;
    end
  end

  coord_scale #(.RES(H_RES), .OUT_W(PIX_X_W)) u_scale_x (
    .clk   (iCLK),
    .rst_n (iRST_n),
    .en    (scale_en),
    .avg   (avg_q.x),
    .pix   (oX_PIX)
  );

  coord_scale #(.RES(V_RES), .OUT_W(PIX_Y_W)) u_scale_y (
    .clk   (iCLK),
    .rst_n (iRST_n),
    .en    (scale_en),
    .avg   (avg_q.y),
    .pix   (oY_PIX)
  );

  assign oNEW_COORD   = new_coord_q;
  assign oTOUCH_VALID = valid_q;
  assign oRELEASE     = rel_pulse_q;
  assign oREJECT_CNT  = rej_q;

endmodule

// File: tb/tb_touch_coord_filter.sv
// Self-checking bench for touch_coord_filter: directed table, corner-case
// sequences, and randomized blocks against an arithmetic reference model.
module tb_touch_coord_filter;

  logic        iCLK = 1'b0;
  logic        iRST_n, iTOUCH_IRQ, iNEW_COORD;
  logic [11:0] iX_COORD, iY_COORD;
  logic [9:0]  oX_PIX;
  logic [8:0]  oY_PIX;
  logic        oNEW_COORD, oTOUCH_VALID, oRELEASE;
  logic [7:0]  oREJECT_CNT;

  touch_coord_filter dut (
    .iCLK         (iCLK),
    .iRST_n       (iRST_n),
    .iTOUCH_IRQ   (iTOUCH_IRQ),
    .iX_COORD     (iX_COORD),
    .iY_COORD     (iY_COORD),
    .iNEW_COORD   (iNEW_COORD),
    .oX_PIX       (oX_PIX),
    .oY_PIX       (oY_PIX),
    .oNEW_COORD   (oNEW_COORD),
    .oTOUCH_VALID (oTOUCH_VALID),
    .oRELEASE     (oRELEASE),
    .oREJECT_CNT  (oREJECT_CNT)
  );

  always #5 iCLK = ~iCLK;

  int tests = 0;
  int fails = 0;
  int rel_seen = 0;

  always @(negedge iCLK) if (iRST_n === 1'b1 && oRELEASE === 1'b1) rel_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0][11:0] xs;
    logic [3:0][11:0] ys;
    logic [9:0]       ex;
    logic [8:0]       ey;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic send(input int x, input int y);
    iNEW_COORD = 1'b1;
    iX_COORD   = 12'(x);
    iY_COORD   = 12'(y);
    step();
    iNEW_COORD = 1'b0;
  endtask

  // Returns in the strobe cycle (checked first, before advancing).
  task automatic wait_strobe(output int gx, output int gy);
    bit seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (oNEW_COORD === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check("strobe_seen", 32'(seen), 32'd1);
    gx = int'(oX_PIX);
    gy = int'(oY_PIX);
  endtask

  task automatic run_block(input logic [3:0][11:0] xs, input logic [3:0][11:0] ys,
                           input int ex, input int ey, input string name);
    int gx, gy;
    for (int k = 0; k < 4; k++) send(int'(xs[k]), int'(ys[k]));
    wait_strobe(gx, gy);
    check({name, "_x"}, gx, ex);
    check({name, "_y"}, gy, ey);
    check({name, "_valid"}, 32'(oTOUCH_VALID), 32'd1);
    step();
  endtask

  function automatic logic [3:0][11:0] rep4(input int v);
    return {4{12'(v)}};
  endfunction

  function automatic int pix_of(input int avg, input int res);
    return (avg * res) / 4096;
  endfunction

  function automatic int clamp12(input int v);
    return (v < 0) ? 0 : (v > 4095) ? 4095 : v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  initial begin
    int gx, gy, sx, sy, base_x, base_y;
    int ref_x, ref_y, sum_x, sum_y, n, rej_exp, outs;

    tbl[0] = '{xs: {12'd2048, 12'd2050, 12'd2046, 12'd2048}, ys: rep4(1024), ex: 400, ey: 120};
    tbl[1] = '{xs: rep4(4095), ys: rep4(4095), ex: 799, ey: 479};
    tbl[2] = '{xs: rep4(0), ys: rep4(0), ex: 0, ey: 0};
    tbl[3] = '{xs: rep4(1000), ys: rep4(1000), ex: 195, ey: 117};
    tbl[4] = '{xs: {12'd3000, 12'd3010, 12'd2990, 12'd3004},
               ys: {12'd100, 12'd110, 12'd90, 12'd104}, ex: 586, ey: 11};

    iRST_n = 1'b0; iTOUCH_IRQ = 1'b0; iNEW_COORD = 1'b0; iX_COORD = '0; iY_COORD = '0;
    repeat (3) step();
    check("rst_x", 32'(oX_PIX), 0);
    check("rst_y", 32'(oY_PIX), 0);
    check("rst_new", 32'(oNEW_COORD), 0);
    check("rst_valid", 32'(oTOUCH_VALID), 0);
    check("rst_release", 32'(oRELEASE), 0);
    check("rst_rej", 32'(oREJECT_CNT), 0);
    iRST_n = 1'b1;
    iTOUCH_IRQ = 1'b1;
    step();

    // Exact latency: strobe in the 3rd cycle after the final accept, one cycle wide.
    send(2048, 1024); send(2050, 1024); send(2046, 1024); send(2048, 1024);
    check("lat_c1", 32'(oNEW_COORD), 0);
    step();
    check("lat_c2", 32'(oNEW_COORD), 0);
    step();
    check("lat_c3", 32'(oNEW_COORD), 1);
    check("lat_x", 32'(oX_PIX), 400);
    check("lat_y", 32'(oY_PIX), 120);
    check("lat_valid", 32'(oTOUCH_VALID), 1);
    step();
    check("strobe_one_cycle", 32'(oNEW_COORD), 0);

    for (int i = 0; i < 5; i++) begin
      run_block(tbl[i].xs, tbl[i].ys, int'(tbl[i].ex), int'(tbl[i].ey), $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_rej", i), 32'(oREJECT_CNT), 0);
    end

    // Outlier restart.
    send(2048, 2048);
    run_block(rep4(2200), rep4(2048), 429, 240, "outlier");
    check("outlier_rej", 32'(oREJECT_CNT), 1);

    // Strobes with IRQ low are ignored.
    iTOUCH_IRQ = 1'b0;
    iNEW_COORD = 1'b1; iX_COORD = 12'd100; iY_COORD = 12'd100;
    repeat (3) step();
    iNEW_COORD = 1'b0;
    iTOUCH_IRQ = 1'b1;
    step();
    run_block(rep4(2048), rep4(1024), 400, 120, "irq_low_ign");
    check("irq_low_rej", 32'(oREJECT_CNT), 1);

    // Samples during AVG/SCALE are dropped.
    for (int k = 0; k < 4; k++) send(2048, 1024);
    iNEW_COORD = 1'b1; iX_COORD = 12'd4000; iY_COORD = 12'd4000;
    step();
    step();
    iNEW_COORD = 1'b0;
    wait_strobe(gx, gy);
    check("busy_x", gx, 400);
    check("busy_y", gy, 120);
    step();
    run_block(rep4(1000), rep4(1000), 195, 117, "after_busy");
    check("busy_rej", 32'(oREJECT_CNT), 1);

    // Release: 999 low cycles do nothing, 1000 fire exactly one pulse.
    iTOUCH_IRQ = 1'b0;
    repeat (999) step();
    iTOUCH_IRQ = 1'b1;
    step();
    check("rel999_count", rel_seen, 0);
    check("rel999_valid", 32'(oTOUCH_VALID), 1);
    iTOUCH_IRQ = 1'b0;
    repeat (1000) step();
    check("rel_pulse", 32'(oRELEASE), 1);
    check("rel_valid", 32'(oTOUCH_VALID), 0);
    check("rel_x_hold", 32'(oX_PIX), 195);
    check("rel_y_hold", 32'(oY_PIX), 117);
    repeat (20) step();
    check("rel_count", rel_seen, 1);
    check("rel_low_after", 32'(oRELEASE), 0);
    iTOUCH_IRQ = 1'b1;
    step();

    // Reset mid-block discards the partial accumulation.
    send(3000, 3000);
    send(3000, 3000);
    #2 iRST_n = 1'b0;
    #1;
    check("midrst_x", 32'(oX_PIX), 0);
    check("midrst_y", 32'(oY_PIX), 0);
    check("midrst_valid", 32'(oTOUCH_VALID), 0);
    check("midrst_rej", 32'(oREJECT_CNT), 0);
    step();
    iRST_n = 1'b1;
    step();
    run_block(rep4(1000), rep4(1000), 195, 117, "post_rst");

    // Randomized blocks against the arithmetic model.
    n = 0; rej_exp = 0; outs = 0;
    ref_x = 0; ref_y = 0; sum_x = 0; sum_y = 0;
    base_x = int'($urandom_range(0, 4095));
    base_y = int'($urandom_range(0, 4095));
    for (int it = 0; it < 800 && outs < 25; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        base_x = int'($urandom_range(0, 4095));
        base_y = int'($urandom_range(0, 4095));
      end
      sx = clamp12(base_x + int'($urandom_range(0, 80)) - 40);
      sy = clamp12(base_y + int'($urandom_range(0, 80)) - 40);
      repeat ($urandom_range(0, 2)) step();
      send(sx, sy);
      if (n == 0) begin
        ref_x = sx; ref_y = sy; sum_x = sx; sum_y = sy; n = 1;
      end else if (iabs(sx - ref_x) > 64 || iabs(sy - ref_y) > 64) begin
        ref_x = sx; ref_y = sy; sum_x = sx; sum_y = sy; n = 1;
        if (rej_exp < 255) rej_exp++;
      end else begin
        sum_x += sx; sum_y += sy; n++;
      end
      if (n == 4) begin
        wait_strobe(gx, gy);
        check("rnd_x", gx, pix_of(sum_x / 4, 800));
        check("rnd_y", gy, pix_of(sum_y / 4, 480));
        check("rnd_rej", 32'(oREJECT_CNT), rej_exp);
        step();
        n = 0;
        outs++;
      end
    end
    check("rnd_blocks", outs, 25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
